led_frame_bank_ctrl: RTL and testbench

// Ping-pong frame-buffer controller for the LED display path. Owns the two-port

---
 rtl/led_frame_bank_ctrl.sv | 149 ++++++++++++++
 tb/tb_led_frame_bank_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_bank_ctrl.sv
// Ping-pong frame-buffer controller: fills the back bank of a two-port SRAM while
// the scan reader drains the front bank; banks swap on vsync once the back frame is complete.
module led_frame_bank_ctrl #(
    parameter int unsigned DW          = 16,
    parameter int unsigned AW          = 9,
    parameter int unsigned FRAME_WORDS = 512
) (
    input  logic          GCK,
    input  logic          rst,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          vsync_pulse,
    input  logic          rd_req,
    output logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          frame_repeat,
    output logic          CENA,
    output logic [AW:0]   AA,
    input  logic [DW-1:0] QA,
    output logic          CENB,
    output logic [AW:0]   AB,
    output logic [DW-1:0] DB
);

    localparam logic [AW-1:0] LAST_OFF = AW'(FRAME_WORDS - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } wstate_t;

    wstate_t       wstate;
    wstate_t       wstate_next;
    logic          wr_ready_next;

    logic          front;
    logic          front_valid;
    logic          swap_pend;
    logic [AW-1:0] woff;
    logic [AW-1:0] roff;
    logic          rd_pend;
    logic          last_pend;

    logic          wr_hs;
    logic          rd_acc;
    logic          swap_now;
    logic          roff_idle;
    logic          woff_last;
    logic          roff_last;

    // A swap is only safe between read frames, so a pending request waits for roff to wrap.
    assign roff_idle = (roff == '0);
    assign woff_last = (woff == LAST_OFF);
    assign roff_last = (roff == LAST_OFF);
    assign swap_now  = (wstate == FULL) && roff_idle && (vsync_pulse || swap_pend);
    assign rd_ready  = front_valid & ~swap_now;
    assign rd_acc    = rd_req & rd_ready;
    assign wr_hs     = wr_valid & wr_ready;
    assign rd_data   = QA;

    // Writer state register
    always_ff @(posedge GCK or posedge rst) begin
        if (rst) begin
            wstate   <= FILL;
            wr_ready <= 1'b1;
        end else begin
            wstate   <= wstate_next;
            wr_ready <= wr_ready_next;
        end
    end

    // Writer next state: FULL after the last pixel lands, back to FILL on a swap
    always_comb begin
        wstate_next   = wstate;
        wr_ready_next = 1'b0;
        unique case (wstate)
            FILL: if (wr_hs && woff_last) wstate_next = FULL;
            FULL: if (swap_now)           wstate_next = FILL;
        endcase
        wr_ready_next = (wstate_next == FILL);
    end

    // Write port: one SRAM write the cycle after each accepted pixel
    always_ff @(posedge GCK or posedge rst) begin
        if (rst) begin
            CENB <= 1'b1;
            AB   <= '0;
            DB   <= '0;
            woff <= '0;
        end else begin
            CENB <= ~wr_hs;
            if (wr_hs) begin
                AB <= {~front, woff};
                DB <= wr_data;
            end
            if (swap_now) begin
                woff <= '0;
            end else if (wr_hs) begin
                woff <= woff_last ? '0 : woff + AW'(1);
            end
        end
    end

    // Read port: address issued one cycle after accept, data returns the cycle after that
    always_ff @(posedge GCK or posedge rst) begin
        if (rst) begin
            CENA      <= 1'b1;
            AA        <= '0;
            roff      <= '0;
            rd_pend   <= 1'b0;
            last_pend <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
        end else begin
            CENA <= ~rd_acc;
            if (rd_acc) begin
                AA   <= {front, roff};
                roff <= roff_last ? '0 : roff + AW'(1);
            end
            rd_pend   <= rd_acc;
            last_pend <= rd_acc & roff_last;
            rd_valid  <= rd_pend;
            rd_last   <= last_pend;
        end
    end

    // Bank ownership and frame-repeat signalling
    always_ff @(posedge GCK or posedge rst) begin
        if (rst) begin
            front        <= 1'b0;
            front_valid  <= 1'b0;
            swap_pend    <= 1'b0;
            frame_repeat <= 1'b0;
        end else begin
            frame_repeat <= vsync_pulse & (wstate == FILL) & front_valid;
            if (swap_now) begin
                front       <= ~front;
                front_valid <= 1'b1;
                swap_pend   <= 1'b0;
            end else if (vsync_pulse && (wstate == FULL)) begin
                swap_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_frame_bank_ctrl.sv
// Bench for led_frame_bank_ctrl: SRAM model, frame-level reference model checked every
// cycle, directed bank-swap scenarios followed by randomized traffic.
module tb_led_frame_bank_ctrl;

    localparam int DW = 16;
    localparam int AW = 9;
    localparam int FW = 512;

    logic          GCK = 1'b0;
    logic          rst = 1'b0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          vsync_pulse = 1'b0;
    logic          rd_req = 1'b0;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          frame_repeat;
    logic          CENA;
    logic [AW:0]   AA;
    logic [DW-1:0] QA = '0;
    logic          CENB;
    logic [AW:0]   AB;
    logic [DW-1:0] DB;

    int checks = 0;
    int errors = 0;

    led_frame_bank_ctrl #(.DW(DW), .AW(AW), .FRAME_WORDS(FW)) dut (
        .GCK(GCK), .rst(rst),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .vsync_pulse(vsync_pulse),
        .rd_req(rd_req), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_last(rd_last), .frame_repeat(frame_repeat),
        .CENA(CENA), .AA(AA), .QA(QA),
        .CENB(CENB), .AB(AB), .DB(DB)
    );

    always #5 GCK = ~GCK;

    // Two-port SRAM: synchronous read, one cycle latency
    logic [DW-1:0] mem [0:2*FW-1];
    always @(posedge GCK) begin
        if (!CENB) mem[AB] <= DB;
        if (!CENA) QA <= mem[AA];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame contents, fill count and read position per bank
    bit m_front, m_fv, m_pend;
    int m_fill, m_rpos;
    int back_frame [FW];
    int front_frame [FW];
    bit e_cena, e_cenb, e_frep;
    int e_aa, e_ab, e_db;
    bit e1_v, e1_l, e2_v, e2_l;
    int e1_d, e2_d;
    bit mf, ms, mr, mh, ma;

    function automatic bit model_swap();
        return (m_fill == FW) && (m_rpos == 0) && (vsync_pulse || m_pend);
    endfunction

    always @(posedge GCK or posedge rst) begin
        if (rst) begin
            m_front = 0; m_fv = 0; m_pend = 0; m_fill = 0; m_rpos = 0;
            e_cena = 1; e_cenb = 1; e_frep = 0;
            e_aa = 0; e_ab = 0; e_db = 0;
            e1_v = 0; e1_l = 0; e2_v = 0; e2_l = 0; e1_d = 0; e2_d = 0;
        end else begin
            mf = (m_fill == FW);
            ms = model_swap();
            mr = m_fv && !ms;
            mh = wr_valid && !mf;
            ma = rd_req && mr;
            e2_v = e1_v; e2_l = e1_l; e2_d = e1_d;
            e1_v = ma;
            e1_l = ma && (m_rpos == FW - 1);
            if (ma) e1_d = front_frame[m_rpos];
            e_cena = !ma;
            if (ma) e_aa = (m_front ? FW : 0) + m_rpos;
            e_cenb = !mh;
            if (mh) begin
                e_ab = (m_front ? 0 : FW) + m_fill;
                e_db = int'(wr_data);
                back_frame[m_fill] = int'(wr_data);
                m_fill++;
            end
            e_frep = vsync_pulse && !mf && m_fv;
            if (ma) m_rpos = (m_rpos + 1) % FW;
            if (ms) begin
                m_front = !m_front;
                m_fv = 1;
                m_pend = 0;
                front_frame = back_frame;
                m_fill = 0;
            end else if (vsync_pulse && mf) begin
                m_pend = 1;
            end
        end
    end

    // Per-cycle comparison against the model, plus event counters for the directed checks
    int n_wr = 0, n_rv = 0, n_last = 0;
    int last_data = -1;

    always @(negedge GCK) begin
        if (rd_valid) n_rv++;
        if (rst) begin
            check("rst_CENA", CENA, 1);
            check("rst_CENB", CENB, 1);
            check("rst_wr_ready", wr_ready, 1);
            check("rst_rd_valid", rd_valid, 0);
            check("rst_frame_repeat", frame_repeat, 0);
        end else begin
            if (!CENB) n_wr++;
            if (rd_valid && rd_last) begin
                n_last++;
                last_data = int'(rd_data);
            end
            check("wr_ready", wr_ready, (m_fill != FW));
            check("rd_ready", rd_ready, m_fv && !model_swap());
            check("CENA", CENA, e_cena);
            if (!e_cena) check("AA", AA, e_aa);
            check("CENB", CENB, e_cenb);
            if (!e_cenb) begin
                check("AB", AB, e_ab);
                check("DB", DB, e_db);
            end
            check("rd_valid", rd_valid, e2_v);
            if (e2_v) check("rd_data", rd_data, e2_d);
            check("rd_last", rd_last, e2_v && e2_l);
            check("frame_repeat", frame_repeat, e_frep);
        end
    end

    task automatic step();
        @(posedge GCK);
        #1;
    endtask

    task automatic write_words(input int n, input bit indexed, input int base);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = indexed ? DW'(base + i) : DW'($urandom);
            step();
        end
        wr_valid = 1'b0;
    endtask

    int b_wr, b_rv, b_last;

    initial begin
        // Reset state
        #1 rst = 1'b1;
        repeat (3) step();
        check("reset_CENA", CENA, 1);
        check("reset_CENB", CENB, 1);
        check("reset_AA", AA, 0);
        check("reset_AB", AB, 0);
        check("reset_DB", DB, 0);
        check("reset_wr_ready", wr_ready, 1);
        check("reset_rd_ready", rd_ready, 0);
        rst = 1'b0;
        step();

        // First frame: data = index into bank 1 (front is 0)
        b_wr = n_wr;
        write_words(FW, 1'b1, 0);
        check("full_wr_ready", wr_ready, 0);
        repeat (2) step();
        check("write_count", n_wr - b_wr, FW);

        // Swap, then drain the whole frame
        vsync_pulse = 1'b1;
        step();
        vsync_pulse = 1'b0;
        check("swap_wr_ready", wr_ready, 1);
        check("swap_rd_ready", rd_ready, 1);
        b_rv = n_rv; b_last = n_last;
        rd_req = 1'b1;
        step();
        check("first_read_CENA", CENA, 0);
        check("first_read_AA", AA, 10'h200);
        repeat (FW - 1) step();
        rd_req = 1'b0;
        repeat (3) step();
        check("read_count", n_rv - b_rv, FW);
        check("last_count", n_last - b_last, 1);
        check("last_data", last_data, FW - 1);

        // Vsync mid-read: swap deferred until the reader wraps
        rd_req = 1'b1;
        for (int i = 0; i < FW; i++) begin
            if (i == 100) rd_req = 1'b0;
            wr_valid = 1'b1;
            wr_data  = DW'($urandom);
            step();
        end
        wr_valid = 1'b0;
        check("full2_wr_ready", wr_ready, 0);
        vsync_pulse = 1'b1;
        step();
        vsync_pulse = 1'b0;
        check("deferred_wr_ready", wr_ready, 0);
        check("deferred_rd_ready", rd_ready, 1);
        rd_req = 1'b1;
        repeat (FW - 100) step();
        check("swap_cycle_rd_ready", rd_ready, 0);
        rd_req = 1'b0;
        step();
        check("post_swap_wr_ready", wr_ready, 1);
        check("post_swap_rd_ready", rd_ready, 1);

        // Vsync with a half-filled back bank repeats the front frame
        write_words(FW / 2, 1'b0, 0);
        vsync_pulse = 1'b1;
        step();
        vsync_pulse = 1'b0;
        check("half_frame_repeat", frame_repeat, 1);
        check("half_wr_ready", wr_ready, 1);
        step();
        check("half_frame_repeat_end", frame_repeat, 0);

        // Last write coincides with vsync: no swap, repeat, swap on next vsync
        write_words(FW / 2 - 1, 1'b0, 0);
        wr_valid = 1'b1; wr_data = DW'($urandom); vsync_pulse = 1'b1;
        step();
        wr_valid = 1'b0; vsync_pulse = 1'b0;
        check("coincide_frame_repeat", frame_repeat, 1);
        check("coincide_wr_ready", wr_ready, 0);
        step();
        vsync_pulse = 1'b1;
        step();
        vsync_pulse = 1'b0;
        check("next_vsync_wr_ready", wr_ready, 1);
        check("next_vsync_frame_repeat", frame_repeat, 0);

        // Randomized traffic
        for (int c = 0; c < 8000; c++) begin
            wr_valid    = ($urandom_range(0, 9) < 7);
            wr_data     = DW'($urandom);
            rd_req      = ($urandom_range(0, 9) < 6);
            vsync_pulse = ($urandom_range(0, 299) == 0);
            step();
        end
        wr_valid = 1'b0; rd_req = 1'b0; vsync_pulse = 1'b0;

        // Async reset during a write burst with a read in flight
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        write_words(FW, 1'b0, 0);
        vsync_pulse = 1'b1;
        step();
        vsync_pulse = 1'b0;
        wr_valid = 1'b1; rd_req = 1'b1;
        for (int i = 0; i < 300; i++) begin
            wr_data = DW'($urandom);
            step();
        end
        #2 rst = 1'b1;
        #1;
        b_rv = n_rv;
        check("async_CENA", CENA, 1);
        check("async_CENB", CENB, 1);
        check("async_AA", AA, 0);
        check("async_AB", AB, 0);
        check("async_wr_ready", wr_ready, 1);
        check("async_rd_ready", rd_ready, 0);
        check("async_rd_valid", rd_valid, 0);
        repeat (2) step();
        rst = 1'b0;
        wr_valid = 1'b0;
        repeat (10) step();
        check("post_reset_rd_ready", rd_ready, 0);
        check("post_reset_rd_valid_count", n_rv - b_rv, 0);
        rd_req = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
